// File: rtl/imsic_topei_scan.sv
// ---------------------------------------------------------------------------
// imsic_topei_scan
//
// Multi-cycle priority scanner for the IMSIC interrupt files (M, S, VS...).
// Every cycle one CHUNK-wide slice of the current file's eip/eie arrays is
// examined. The lowest qualifying identity seen during a pass is kept in
// best_r and written into that file's topei register when the pass ends.
// The FSM then moves on to the next file, round-robin, and never idles
// again after the first cycle out of reset.
//
// Optional build macro:
//   IMSIC_SCAN_EARLY_EXIT_EN - leave SCAN as soon as a chunk produces a
//   candidate. Chunks are visited lowest-first, so the result is the same
//   as a full pass; only the latency changes.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_eip, i_eie       pending / enable bits, file f at [f*NR_SRC +: NR_SRC]
//   i_eithreshold      per-file threshold (0 = no threshold), ID_W each
//   i_eidelivery       per-file delivery enable
//   i_claim_vld        claim strobe (CSR write to *topei)
//   i_claim_file       file being claimed (>= NR_FILES is ignored)
//   o_topei            per-file top identity (0 = none), ID_W each
//   o_irq              per-file interrupt request
//   o_clr_vld          one-cycle clear-pending strobe after a claim
//   o_clr_file         file of the bit to clear
//   o_clr_id           identity to clear
// ---------------------------------------------------------------------------
module imsic_topei_scan #(
    parameter int NR_SRC   = 256,
    parameter int NR_FILES = 3,
    parameter int CHUNK    = 32,
    parameter int ID_W     = $clog2(NR_SRC),
    parameter int FILE_W   = (NR_FILES > 1) ? $clog2(NR_FILES) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NR_FILES*NR_SRC-1:0] i_eip,
    input  logic [NR_FILES*NR_SRC-1:0] i_eie,
    input  logic [NR_FILES*ID_W-1:0]   i_eithreshold,
    input  logic [NR_FILES-1:0]        i_eidelivery,
    input  logic                       i_claim_vld,
    input  logic [FILE_W-1:0]          i_claim_file,
    output logic [NR_FILES*ID_W-1:0]   o_topei,
    output logic [NR_FILES-1:0]        o_irq,
    output logic                       o_clr_vld,
    output logic [FILE_W-1:0]          o_clr_file,
    output logic [ID_W-1:0]            o_clr_id
);

    localparam int NR_CHUNKS = NR_SRC / CHUNK;
    localparam int CPTR_W    = (NR_CHUNKS > 1) ? $clog2(NR_CHUNKS) : 1;

    localparam logic [ID_W-1:0]   ID_ZERO    = {ID_W{1'b0}};
    localparam logic [CPTR_W-1:0] CPTR_ZERO  = {CPTR_W{1'b0}};
    localparam logic [FILE_W-1:0] FILE_ZERO  = {FILE_W{1'b0}};
    localparam logic [CPTR_W-1:0] LAST_CHUNK = CPTR_W'(NR_CHUNKS - 1);
    localparam logic [FILE_W-1:0] LAST_FILE  = FILE_W'(NR_FILES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    state_e            state_r;
    logic [FILE_W-1:0] file_r;
    logic [CPTR_W-1:0] chunk_r;
    logic [ID_W-1:0]   best_r;
    logic [ID_W-1:0]   topei_r [NR_FILES];
    logic              clr_vld_r;
    logic [FILE_W-1:0] clr_file_r;
    logic [ID_W-1:0]   clr_id_r;

    logic [CHUNK-1:0]  chunk_eip_s;
    logic [CHUNK-1:0]  chunk_eie_s;
    logic [ID_W-1:0]   thresh_s;
    logic [ID_W-1:0]   chunk_base_s;
    logic [CHUNK-1:0]  cand_s;
    logic              hit_s;
    logic [ID_W-1:0]   hit_id_s;
    logic              claim_ok_s;
    logic              claim_here_s;
    logic [ID_W-1:0]   claim_topei_s;

    // Live slice of the file/chunk under the scan pointers (no snapshot).
    always_comb begin
        chunk_eip_s  = i_eip[int'(file_r)*NR_SRC + int'(chunk_r)*CHUNK +: CHUNK];
        chunk_eie_s  = i_eie[int'(file_r)*NR_SRC + int'(chunk_r)*CHUNK +: CHUNK];
        thresh_s     = i_eithreshold[int'(file_r)*ID_W +: ID_W];
        chunk_base_s = ID_W'(int'(chunk_r) * CHUNK);
    end

    // Candidate mask: pending, enabled, not ID 0, and strictly below a non-zero threshold.
    always_comb begin
        cand_s = {CHUNK{1'b0}};
        for (int i = 0; i < CHUNK; i++) begin
            cand_s[i] = chunk_eip_s[i] & chunk_eie_s[i]
                      & ((chunk_base_s | ID_W'(i)) != ID_ZERO)
                      & ((thresh_s == ID_ZERO) | ((chunk_base_s | ID_W'(i)) < thresh_s));
        end
    end

    // Lowest set candidate wins; walking downwards lets the lowest index overwrite last.
    always_comb begin
        hit_id_s = ID_ZERO;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (cand_s[i]) begin
                hit_id_s = chunk_base_s | ID_W'(i);
            end else begin
                hit_id_s = hit_id_s;
            end
        end
        hit_s = |cand_s;
    end

    // Claim decode; the width-extended compare also covers power-of-two file counts.
    always_comb begin
        claim_ok_s   = i_claim_vld & ({1'b0, i_claim_file} < (FILE_W + 1)'(NR_FILES));
        claim_here_s = claim_ok_s & (i_claim_file == file_r);
        if (claim_ok_s) begin
            claim_topei_s = topei_r[i_claim_file];
        end else begin
            claim_topei_s = ID_ZERO;
        end
    end

    // Scan FSM, per-file topei registers and the claim/clear strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            file_r     <= FILE_ZERO;
            chunk_r    <= CPTR_ZERO;
            best_r     <= ID_ZERO;
            clr_vld_r  <= 1'b0;
            clr_file_r <= FILE_ZERO;
            clr_id_r   <= ID_ZERO;
            for (int f = 0; f < NR_FILES; f++) begin
                topei_r[f] <= ID_ZERO;
            end
        end else begin
            clr_vld_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_SCAN;
                    chunk_r <= CPTR_ZERO;
                    best_r  <= ID_ZERO;
                end
                ST_SCAN: begin
                    if (claim_here_s) begin
                        // The claimed ID may already sit in best_r; restart so it is never committed.
                        chunk_r <= CPTR_ZERO;
                        best_r  <= ID_ZERO;
                    end else begin
                        if (hit_s && (best_r == ID_ZERO)) begin
                            best_r <= hit_id_s;
                        end
`ifdef IMSIC_SCAN_EARLY_EXIT_EN
                        if (hit_s || (chunk_r == LAST_CHUNK)) begin
                            state_r <= ST_COMMIT;
                        end else begin
                            chunk_r <= chunk_r + CPTR_W'(1);
                        end
`else
                        if (chunk_r == LAST_CHUNK) begin
                            state_r <= ST_COMMIT;
                        end else begin
                            chunk_r <= chunk_r + CPTR_W'(1);
                        end
`endif
                    end
                end
                ST_COMMIT: begin
                    topei_r[file_r] <= best_r;
                    if (file_r == LAST_FILE) begin
                        file_r <= FILE_ZERO;
                    end else begin
                        file_r <= file_r + FILE_W'(1);
                    end
                    chunk_r <= CPTR_ZERO;
                    best_r  <= ID_ZERO;
                    state_r <= ST_SCAN;
                end
                default: begin
                    state_r <= ST_IDLE;
                    chunk_r <= CPTR_ZERO;
                    best_r  <= ID_ZERO;
                end
            endcase

            // Placed after the FSM so a claim overrides a same-cycle COMMIT of that file.
            if (claim_ok_s) begin
                topei_r[i_claim_file] <= ID_ZERO;
                if (claim_topei_s != ID_ZERO) begin
                    clr_vld_r  <= 1'b1;
                    clr_file_r <= i_claim_file;
                    clr_id_r   <= claim_topei_s;
                end
            end
        end
    end

    genvar gf;
    generate
        for (gf = 0; gf < NR_FILES; gf++) begin : g_out
            assign o_topei[gf*ID_W +: ID_W] = topei_r[gf];
            assign o_irq[gf] = (topei_r[gf] != ID_ZERO) & i_eidelivery[gf];
        end
    endgenerate

    assign o_clr_vld  = clr_vld_r;
    assign o_clr_file = clr_file_r;
    assign o_clr_id   = clr_id_r;

endmodule

// File: tb/tb_imsic_topei_scan.sv
// ---------------------------------------------------------------------------
// tb_imsic_topei_scan
//
// Directed bench for imsic_topei_scan with default parameters. Claims push
// the expected clear strobe into a queue; an independent monitor pops and
// compares whenever o_clr_vld is seen. topei/irq values and scan timing
// are checked directly against hand-computed values.
// ---------------------------------------------------------------------------
module tb_imsic_topei_scan;

    localparam int NR_SRC   = 256;
    localparam int NR_FILES = 3;
    localparam int CHUNK    = 32;
    localparam int ID_W     = 8;

`ifdef IMSIC_SCAN_EARLY_EXIT_EN
    localparam int FIRST_COMMIT = 3;
`else
    localparam int FIRST_COMMIT = 10;
`endif

    typedef struct packed {
        logic [1:0] file;
        logic [7:0] id;
    } clr_t;

    logic                       clk;
    logic                       rst;
    logic [NR_FILES*NR_SRC-1:0] eip;
    logic [NR_FILES*NR_SRC-1:0] eie;
    logic [NR_FILES*ID_W-1:0]   thresh;
    logic [NR_FILES-1:0]        deliv;
    logic                       claim_vld;
    logic [1:0]                 claim_file;
    logic [NR_FILES*ID_W-1:0]   topei;
    logic [NR_FILES-1:0]        irq;
    logic                       clr_vld;
    logic [1:0]                 clr_file;
    logic [ID_W-1:0]            clr_id;

    int   checks   = 0;
    int   failures = 0;
    clr_t exp_q[$];
    clr_t mon_e;

    imsic_topei_scan #(
        .NR_SRC   (NR_SRC),
        .NR_FILES (NR_FILES),
        .CHUNK    (CHUNK)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_eip         (eip),
        .i_eie         (eie),
        .i_eithreshold (thresh),
        .i_eidelivery  (deliv),
        .i_claim_vld   (claim_vld),
        .i_claim_file  (claim_file),
        .o_topei       (topei),
        .o_irq         (irq),
        .o_clr_vld     (clr_vld),
        .o_clr_file    (clr_file),
        .o_clr_id      (clr_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor for the clear strobe.
    always @(negedge clk) begin
        if (!rst && clr_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL clr_unexpected: got file=%0d id=%0d, required no strobe", clr_file, clr_id);
            end else begin
                mon_e = exp_q.pop_front();
                if (clr_file !== mon_e.file || clr_id !== mon_e.id) begin
                    failures++;
                    $display("FAIL clr_strobe: got file=%0d id=%0d, required file=%0d id=%0d",
                             clr_file, clr_id, mon_e.file, mon_e.id);
                end
            end
        end
    end

    function automatic logic [7:0] topei_of(input int f);
        return topei[f*ID_W +: ID_W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic set_src(input int f, input int id, input logic val);
        eip[f*NR_SRC + id] = val;
        eie[f*NR_SRC + id] = val;
    endtask

    task automatic wait_topei(input int f, input logic [7:0] exp, input int budget, input string name);
        int n;
        n = 0;
        while (topei_of(f) !== exp && n < budget) begin
            step();
            n++;
        end
        chk(name, {24'd0, topei_of(f)}, {24'd0, exp});
    endtask

    task automatic claim(input logic [1:0] f);
        claim_vld  = 1'b1;
        claim_file = f;
        step();
        claim_vld  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        eip        = '0;
        eie        = '0;
        thresh     = '0;
        deliv      = 3'b111;
        claim_vld  = 1'b0;
        claim_file = 2'd0;
        set_src(0, 3, 1'b1);
        set_src(1, 200, 1'b1);
        set_src(1, 37, 1'b1);
        set_src(2, 200, 1'b1);
        set_src(2, 37, 1'b1);
        step();
        step();
        rst = 1'b0;

        // Reset state and first commit timing of file 0.
        chk("reset_topei", {8'd0, topei}, 32'd0);
        chk("reset_irq", {29'd0, irq}, 32'd0);
        chk("reset_clr_vld", {31'd0, clr_vld}, 32'd0);
        repeat (FIRST_COMMIT - 1) step();
        chk("topei0_before_commit", {24'd0, topei_of(0)}, 32'd0);
        step();
        chk("topei0_first_commit", {24'd0, topei_of(0)}, 32'd3);
        chk("irq0_first_commit", {31'd0, irq[0]}, 32'd1);

        // File 1 and 2 with IDs 37 and 200; delivery gating of irq.
        wait_topei(1, 8'd37, 27, "topei1_37");
        chk("irq1_on", {31'd0, irq[1]}, 32'd1);
        deliv[1] = 1'b0;
        #1;
        chk("irq1_delivery_off", {31'd0, irq[1]}, 32'd0);
        chk("topei1_held", {24'd0, topei_of(1)}, 32'd37);
        deliv[1] = 1'b1;
        wait_topei(2, 8'd37, 27, "topei2_37");

        // Threshold: ID equal to threshold does not qualify.
        set_src(0, 3, 1'b0);
        set_src(0, 5, 1'b1);
        set_src(0, 40, 1'b1);
        thresh[0*ID_W +: ID_W] = 8'd5;
        repeat (40) step();
        chk("topei0_thresh5", {24'd0, topei_of(0)}, 32'd0);
        chk("irq0_thresh5", {31'd0, irq[0]}, 32'd0);
        claim(2'd0);
        chk("claim_zero_no_strobe", {31'd0, clr_vld}, 32'd0);
        thresh[0*ID_W +: ID_W] = 8'd41;
        wait_topei(0, 8'd5, 40, "topei0_thresh41");

        // Claim file 2 (topei 37), clearing eip[37] at the same time.
        exp_q.push_back('{file: 2'd2, id: 8'd37});
        eip[2*NR_SRC + 37] = 1'b0;
        claim(2'd2);
        chk("topei2_after_claim", {24'd0, topei_of(2)}, 32'd0);
        chk("irq2_after_claim", {31'd0, irq[2]}, 32'd0);
        step();
        chk("clr_vld_one_cycle", {31'd0, clr_vld}, 32'd0);
        wait_topei(2, 8'd200, 40, "topei2_rescan_200");

        // Out-of-range claim file is ignored.
        claim(2'd3);
        chk("oor_claim_no_strobe", {31'd0, clr_vld}, 32'd0);
        chk("oor_claim_topei", {8'd0, topei}, {8'd0, 8'd200, 8'd37, 8'd5});

        // Back-to-back claims on files 1 and 0.
        exp_q.push_back('{file: 2'd1, id: 8'd37});
        claim_vld  = 1'b1;
        claim_file = 2'd1;
        step();
        exp_q.push_back('{file: 2'd0, id: 8'd5});
        claim_file = 2'd0;
        step();
        claim_vld = 1'b0;
        chk("b2b_topei1_cleared", {24'd0, topei_of(1)}, 32'd0);
        chk("b2b_topei0_cleared", {24'd0, topei_of(0)}, 32'd0);
        wait_topei(1, 8'd37, 40, "b2b_topei1_back");
        wait_topei(0, 8'd5, 40, "b2b_topei0_back");

`ifndef IMSIC_SCAN_EARLY_EXIT_EN
        // Mid-run reset, then claim of file 0 while its scan is at chunk 5.
        set_src(0, 40, 1'b0);
        set_src(0, 200, 1'b1);
        thresh[0*ID_W +: ID_W] = 8'd0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrun_reset_topei", {8'd0, topei}, 32'd0);
        repeat (6) step();
        eip[0*NR_SRC + 5] = 1'b0;
        claim(2'd0);
        chk("restart_claim_no_strobe", {31'd0, clr_vld}, 32'd0);
        repeat (3) step();
        chk("restart_no_stale_commit", {24'd0, topei_of(0)}, 32'd0);
        repeat (5) step();
        chk("restart_before_commit", {24'd0, topei_of(0)}, 32'd0);
        step();
        chk("restart_commit_200", {24'd0, topei_of(0)}, 32'd200);

        // Claim of file 1 lands on its COMMIT edge: claim wins, pointer advances.
        repeat (8) step();
        claim(2'd1);
        chk("claim_vs_commit_topei1", {24'd0, topei_of(1)}, 32'd0);
        chk("claim_vs_commit_no_strobe", {31'd0, clr_vld}, 32'd0);
        repeat (8) step();
        chk("file2_before_commit", {24'd0, topei_of(2)}, 32'd0);
        step();
        chk("file2_commit_after_advance", {24'd0, topei_of(2)}, 32'd200);
        chk("topei1_still_cleared", {24'd0, topei_of(1)}, 32'd0);
        repeat (18) step();
        chk("topei1_next_pass", {24'd0, topei_of(1)}, 32'd37);
`endif

        repeat (3) step();
        chk("clr_queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
